logic_gate_bist: RTL
====================

Name: logic_gate_bist

Overview:
- Self-checking stimulus/response engine for the two-input logic_gate block: it drives a/b and reads back and/or/xor/xnor/nand/notb outputs.
- On start it steps through all four input vectors (00, 01, 10, 11), holds each for a programmable settle time, and samples and compares the six gate outputs against internally computed expected values.
- It reports pass/fail, the error count, the first failing vector and a sticky mask of failing outputs.
- It sits beside the gate instance as an on-chip BIST/readback end.

Parameters:
- HOLD_CYCLES, 2, cycles each vector is driven before its sample cycle (legal range ≥1).
- ERR_W, 8, width of the error counter (legal range ≥2).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run the sequence; honoured only in IDLE or DONE.
- a_o  out  1  stimulus to the gate's a input; equals vec[1].
- b_o  out  1  stimulus to the gate's b input; equals vec[0].
- and_in  in  1  gate and_out readback.
- or_in  in  1  gate or_out readback.
- xor_in  in  1  gate xor_out readback.
- xnor_in  in  1  gate xnor_out readback.
- nand_in  in  1  gate nand_out readback.
- notb_in  in  1  gate notb_out readback.
- busy  out  1  high in APPLY and SAMPLE.
- done  out  1  high in DONE; held until the next accepted start or reset.
- pass  out  1  equals done AND (err_cnt==0).
- err_cnt  out  ERR_W  count of vectors with at least one mismatch; saturates at all-ones.
- first_fail_vec  out  2  vector {a,b} of the first mismatching sample; 0 if none.
- fail_mask  out  6  sticky OR of per-output mismatches; bit order [0]and [1]or [2]xor [3]xnor [4]nand [5]notb.

Behaviour:
- Reset (async assert, sync release): state=IDLE; vec=0; hold counter=0.
  - All outputs are 0: a_o, b_o, busy, done, pass, err_cnt, first_fail_vec, fail_mask.
- All outputs are registered. a_o/b_o change only on clock edges.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE or DONE with start=1:
  - Clear err_cnt, fail_mask, first_fail_vec and an internal seen_fail flag.
  - Set vec=0 and go to APPLY.
  - Start in any other state is ignored (no restart, no queuing).
- APPLY: remain exactly HOLD_CYCLES cycles with a_o/b_o stable, then go to SAMPLE.
- SAMPLE (one cycle): compare the readback inputs against expected values for vec.
  - Expected values: and=a&b, or=a|b, xor=a^b, xnor=~(a^b), nand=~(a&b), notb=~b.
  - Form mism[5:0] from the comparison; fail_mask |= mism.
  - If mism≠0: err_cnt increments, saturating at 2^ERR_W−1. If seen_fail=0, first_fail_vec=vec and seen_fail=1.
  - If vec==3, go to DONE; otherwise vec=vec+1 and go to APPLY.
- Latency: done rises 4*(HOLD_CYCLES+1) cycles after the edge that accepted start (12 cycles at the default).
- DONE: a_o/b_o hold the last vector (11). Results stay stable until an accepted start or reset.
- Reset asserted mid-run: the run aborts immediately to reset values; no partial results are retained.
- Readback inputs are only sampled in SAMPLE; their values in other states are don't-care.

Decomposition:
- logic_gate_pkg holds:
  - the FSM state enum (IDLE/APPLY/SAMPLE/DONE);
  - NUM_VEC=4;
  - mask bit index constants (MASK_AND..MASK_NOTB);
  - a function returning the 6-bit expected vector for a given {a,b}.
- One natural sub-module: gate_expect, a purely combinational golden model, {a,b} → expected[5:0], shared with future gate-level checkers.
- The FSM, counters and result registers stay in logic_gate_bist.

Test Plan:
- Correct logic_gate connected, HOLD_CYCLES=2, start pulse → a_o/b_o sequence 00,01,10,11, each vector held 3 cycles; done=1 at cycle 12; pass=1, err_cnt=0, fail_mask=0, first_fail_vec=0.
- and_in stuck at 0 → err_cnt=1, fail_mask=6'b000001, first_fail_vec=2'b11, pass=0.
- notb_in wired to b instead of ~b → err_cnt=4, fail_mask=6'b100000, first_fail_vec=2'b00.
- ERR_W=2, all six readbacks inverted → err_cnt saturates at 3, fail_mask=6'b111111, first_fail_vec=0.
- Start pulsed again during APPLY of vector 01 → ignored; the sequence and done timing are unchanged. Start in DONE → results clear and the run repeats.
- rst_n low during APPLY of vector 10 → busy/done/err_cnt/fail_mask/a_o/b_o all 0 immediately. After release and a new start, the full run completes normally with a correct gate.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// ---------------------------------------------------------------------------
// logic_gate_pkg
// Shared definitions for the logic_gate BIST engine and its golden model:
//   - bist_state_e : FSM states of the stimulus/response engine
//   - NUM_VEC      : number of input vectors exercised ({a,b} = 00..11)
//   - MASK_*       : bit positions of each gate output in mismatch/fail masks
//   - gate_expected: returns the six expected gate outputs for a given {a,b}
// ---------------------------------------------------------------------------
package logic_gate_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } bist_state_e;

    localparam int NUM_VEC   = 4;
    localparam int NUM_OUT   = 6;

    localparam int MASK_AND  = 0;
    localparam int MASK_OR   = 1;
    localparam int MASK_XOR  = 2;
    localparam int MASK_XNOR = 3;
    localparam int MASK_NAND = 4;
    localparam int MASK_NOTB = 5;

    // Expected outputs of a healthy two-input gate block; ab[1] is a, ab[0] is b.
    function automatic logic [NUM_OUT-1:0] gate_expected(input logic [1:0] ab);
        logic                a;
        logic                b;
        logic [NUM_OUT-1:0]  e;
        a            = ab[1];
        b            = ab[0];
        e            = '0;
        e[MASK_AND]  = a & b;
        e[MASK_OR]   = a | b;
        e[MASK_XOR]  = a ^ b;
        e[MASK_XNOR] = ~(a ^ b);
        e[MASK_NAND] = ~(a & b);
        e[MASK_NOTB] = ~b;
        return e;
    endfunction

endpackage

// File: rtl/logic_gate_bist_gate_expect.sv
// ---------------------------------------------------------------------------
// gate_expect
// Purely combinational golden model of the two-input logic_gate block.
// Ports:
//   vec_i      [1:0] input vector {a,b}
//   expected_o [5:0] expected outputs, bit order and/or/xor/xnor/nand/notb
// ---------------------------------------------------------------------------
module gate_expect
    import logic_gate_pkg::*;
(
    input  logic [1:0]         vec_i,
    output logic [NUM_OUT-1:0] expected_o
);

    assign expected_o = gate_expected(vec_i);

endmodule

// File: rtl/logic_gate_bist.sv
// ---------------------------------------------------------------------------
// logic_gate_bist
// On-chip stimulus/response checker for the two-input logic_gate block.
// A start pulse walks {a,b} through 00,01,10,11; each vector is held for
// HOLD_CYCLES cycles, then the six gate readbacks are compared in one SAMPLE
// cycle against the golden model.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request, honoured only in IDLE or DONE
//   a_o, b_o            stimulus to the gate under test
//   and_in..notb_in     gate output readbacks
//   busy, done, pass    run status (registered)
//   err_cnt             saturating count of failing vectors
//   first_fail_vec      {a,b} of the first failing vector, 0 if none
//   fail_mask           sticky per-output mismatch mask
// ---------------------------------------------------------------------------
module logic_gate_bist
    import logic_gate_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    input  logic             and_in,
    input  logic             or_in,
    input  logic             xor_in,
    input  logic             xnor_in,
    input  logic             nand_in,
    input  logic             notb_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       first_fail_vec,
    output logic [5:0]       fail_mask
);

    localparam int              HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [1:0]      LAST_VEC  = 2'(NUM_VEC - 1);

    bist_state_e         state_q;
    logic [1:0]          vec_q;
    logic [HOLD_W-1:0]   holdCnt_q;
    logic                seenFail_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [ERR_W-1:0]    errCnt_q;
    logic [ERR_W-1:0]    errCnt_d;
    logic [1:0]          firstFail_q;
    logic [NUM_OUT-1:0]  failMask_q;
    logic [NUM_OUT-1:0]  failMask_d;
    logic [NUM_OUT-1:0]  expected;
    logic [NUM_OUT-1:0]  readback;
    logic [NUM_OUT-1:0]  mism;

    gate_expect u_gate_expect (
        .vec_i      (vec_q),
        .expected_o (expected)
    );

    // Gather the readbacks in mask bit order so one XOR yields the mismatch
    // vector. The counter saturates so a long-failing part cannot wrap to 0.
    always_comb begin
        readback            = '0;
        readback[MASK_AND]  = and_in;
        readback[MASK_OR]   = or_in;
        readback[MASK_XOR]  = xor_in;
        readback[MASK_XNOR] = xnor_in;
        readback[MASK_NAND] = nand_in;
        readback[MASK_NOTB] = notb_in;
        mism                = readback ^ expected;
        failMask_d          = failMask_q | mism;
        errCnt_d            = errCnt_q;
        if ((|mism) && (errCnt_q != '1)) begin
            errCnt_d = errCnt_q + ERR_W'(1);
        end
    end

    // Sequencer and result registers. Status outputs are kept as their own
    // flops so every output port is driven directly from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            holdCnt_q   <= '0;
            seenFail_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            errCnt_q    <= '0;
            firstFail_q <= '0;
            failMask_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= APPLY;
                        vec_q       <= '0;
                        holdCnt_q   <= '0;
                        seenFail_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        errCnt_q    <= '0;
                        firstFail_q <= '0;
                        failMask_q  <= '0;
                    end
                end
                APPLY: begin
                    if (holdCnt_q == HOLD_LAST) begin
                        state_q   <= SAMPLE;
                        holdCnt_q <= '0;
                    end else begin
                        holdCnt_q <= holdCnt_q + HOLD_W'(1);
                    end
                end
                SAMPLE: begin
                    failMask_q <= failMask_d;
                    errCnt_q   <= errCnt_d;
                    if ((|mism) && !seenFail_q) begin
                        firstFail_q <= vec_q;
                        seenFail_q  <= 1'b1;
                    end
                    if (vec_q == LAST_VEC) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (errCnt_d == '0);
                    end else begin
                        vec_q   <= vec_q + 2'd1;
                        state_q <= APPLY;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_o            = vec_q[1];
    assign b_o            = vec_q[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = errCnt_q;
    assign first_fail_vec = firstFail_q;
    assign fail_mask      = failMask_q;

endmodule
